// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: front-panel, supplier restock and dispenser/hopper signals of vend_ctrl.
// The slave modport is the controller's view; master is the panel/supplier side.
interface vend_ctrl_if #(
  parameter int NUM_ITEMS = 8,
  parameter int MAX_STOCK = 15,
  parameter int PRICE_W   = 8,
  parameter int BAL_W     = 16
);
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int CW = $clog2(MAX_STOCK + 1);

  logic [1:0]         coins;
  logic               select_valid;
  logic [IW-1:0]      select_id;
  logic               cancel;
  logic               restock_valid;
  logic [IW-1:0]      restock_item;
  logic [CW-1:0]      restock_count;
  logic [PRICE_W-1:0] restock_cost;
  logic               busy;
  logic [1:0]         status;
  logic [BAL_W-1:0]   balance;
  logic               product_valid;
  logic [IW-1:0]      product_id;
  logic               change_valid;
  logic [BAL_W-1:0]   change;

  modport master (
    output coins, select_valid, select_id, cancel,
           restock_valid, restock_item, restock_count, restock_cost,
    input  busy, status, balance, product_valid, product_id, change_valid, change
  );

  modport slave (
    input  coins, select_valid, select_id, cancel,
           restock_valid, restock_item, restock_count, restock_cost,
    output busy, status, balance, product_valid, product_id, change_valid, change
  );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-slot vending controller with coin credit, idle watchdog refund and change.
// Defining VEND_LOW_STOCK_EN adds a registered per-slot low_stock output.
module vend_ctrl #(
  parameter int NUM_ITEMS = 8,
  parameter int MAX_STOCK = 15,
  parameter int PRICE_W   = 8,
  parameter int BAL_W     = 16,
  parameter int TIMEOUT   = 512
) (
  input  logic                 clk,
  input  logic                 hrst,
`ifdef VEND_LOW_STOCK_EN
  output logic [NUM_ITEMS-1:0] low_stock,
`endif
  vend_ctrl_if.slave           bus
);
  localparam int IW = $clog2(NUM_ITEMS);
  localparam int CW = $clog2(MAX_STOCK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_AVAIL = 2'b01;
  localparam logic [1:0] ST_OOS   = 2'b10;
  localparam logic [1:0] ST_ERR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RESTOCK, S_CHECK, S_COLLECT, S_DISPENSE, S_REFUND
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [IW-1:0]      r_item_q, r_item_d;
  logic [CW-1:0]      r_count_q, r_count_d;
  logic [PRICE_W-1:0] r_cost_q, r_cost_d;
  logic [BAL_W-1:0]   credit_q, credit_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [CW-1:0]      stock_q [NUM_ITEMS];
  logic [CW-1:0]      stock_d [NUM_ITEMS];
  logic [PRICE_W-1:0] price_q [NUM_ITEMS];
  logic [PRICE_W-1:0] price_d [NUM_ITEMS];
  logic [1:0]         status_q, status_d;
  logic               busy_q, busy_d;
  logic               product_valid_q, product_valid_d;
  logic [IW-1:0]      product_id_q, product_id_d;
  logic               change_valid_q, change_valid_d;
  logic [BAL_W-1:0]   change_q, change_d;

  logic [BAL_W:0]     coin_val;
  logic [BAL_W:0]     credit_sum;
  logic [BAL_W-1:0]   credit_sat;
  logic [CW:0]        restock_sum;

  always_comb begin
    coin_val = '0;
    case (bus.coins)
      2'b01:   coin_val = (BAL_W+1)'(5);
      2'b10:   coin_val = (BAL_W+1)'(10);
      2'b11:   coin_val = (BAL_W+1)'(25);
      default: coin_val = '0;
    endcase
  end

  assign credit_sum  = {1'b0, credit_q} + coin_val;
  assign credit_sat  = credit_sum[BAL_W] ? '1 : credit_sum[BAL_W-1:0];
  assign restock_sum = {1'b0, stock_q[r_item_q]} + {1'b0, r_count_q};

  // Strobes and change are produced on the transition into DISPENSE/REFUND so
  // they are registered and visible for exactly the one cycle spent there.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    r_item_d        = r_item_q;
    r_count_d       = r_count_q;
    r_cost_d        = r_cost_q;
    credit_d        = credit_q;
    timer_d         = timer_q;
    stock_d         = stock_q;
    price_d         = price_q;
    status_d        = status_q;
    product_valid_d = 1'b0;
    product_id_d    = product_id_q;
    change_valid_d  = 1'b0;
    change_d        = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.restock_valid) begin
          r_item_d  = bus.restock_item;
          r_count_d = bus.restock_count;
          r_cost_d  = bus.restock_cost;
          state_d   = S_RESTOCK;
        end else if (bus.select_valid) begin
          sel_d   = bus.select_id;
          state_d = S_CHECK;
        end
      end
      S_RESTOCK: begin
        if (restock_sum > (CW+1)'(MAX_STOCK)) begin
          status_d = ST_ERR;
        end else begin
          stock_d[r_item_q] = restock_sum[CW-1:0];
          status_d          = ST_OK;
        end
        if (r_cost_q != '0) price_d[r_item_q] = r_cost_q;
        state_d = S_IDLE;
      end
      S_CHECK: begin
        if (stock_q[sel_q] == '0 || price_q[sel_q] == '0) begin
          status_d = ST_OOS;
          state_d  = S_IDLE;
        end else begin
          status_d = ST_AVAIL;
          credit_d = '0;
          timer_d  = TIMER_INIT;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.coins != 2'b00) begin
          credit_d = credit_sat;
          timer_d  = TIMER_INIT;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end
        if (credit_q >= BAL_W'(price_q[sel_q])) begin
          state_d         = S_DISPENSE;
          product_valid_d = 1'b1;
          product_id_d    = sel_q;
          change_valid_d  = 1'b1;
          change_d        = credit_d - BAL_W'(price_q[sel_q]);
          status_d        = ST_OK;
        end else if (bus.cancel) begin
          state_d        = S_REFUND;
          change_valid_d = 1'b1;
          change_d       = credit_d;
        end else if (timer_q == '0) begin
          state_d        = S_REFUND;
          change_valid_d = 1'b1;
          change_d       = credit_d;
          status_d       = ST_ERR;
        end
      end
      S_DISPENSE: begin
        stock_d[sel_q] = stock_q[sel_q] - CW'(1);
        credit_d       = '0;
        state_d        = S_IDLE;
      end
      S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      state_q         <= S_IDLE;
      sel_q           <= '0;
      r_item_q        <= '0;
      r_count_q       <= '0;
      r_cost_q        <= '0;
      credit_q        <= '0;
      timer_q         <= TIMER_INIT;
      stock_q         <= '{default: '0};
      price_q         <= '{default: '0};
      status_q        <= ST_OK;
      busy_q          <= 1'b0;
      product_valid_q <= 1'b0;
      product_id_q    <= '0;
      change_valid_q  <= 1'b0;
      change_q        <= '0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      r_item_q        <= r_item_d;
      r_count_q       <= r_count_d;
      r_cost_q        <= r_cost_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      stock_q         <= stock_d;
      price_q         <= price_d;
      status_q        <= status_d;
      busy_q          <= busy_d;
      product_valid_q <= product_valid_d;
      product_id_q    <= product_id_d;
      change_valid_q  <= change_valid_d;
      change_q        <= change_d;
    end
  end

`ifdef VEND_LOW_STOCK_EN
  logic [NUM_ITEMS-1:0] low_stock_q;

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      low_stock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) low_stock_q[i] <= (stock_q[i] <= CW'(1));
    end
  end

  assign low_stock = low_stock_q;
`endif

  assign bus.busy          = busy_q;
  assign bus.status        = status_q;
  assign bus.balance       = credit_q;
  assign bus.product_valid = product_valid_q;
  assign bus.product_id    = product_id_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change        = change_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed, hand-computed vectors for vend_ctrl with TIMEOUT=16.
module tb_vend_ctrl;
  logic clk;
  logic hrst;
  int   checks = 0;
  int   errors = 0;

  vend_ctrl_if #(.NUM_ITEMS(8), .MAX_STOCK(15), .PRICE_W(8), .BAL_W(16)) bus ();

  vend_ctrl #(
    .NUM_ITEMS(8), .MAX_STOCK(15), .PRICE_W(8), .BAL_W(16), .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .hrst (hrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // One clock of stimulus; inputs return to idle right after the sampling edge.
  task automatic applyStimulus(input logic [1:0] c, input logic sv, input logic [2:0] sid,
                               input logic cn, input logic rv, input logic [2:0] ri,
                               input logic [3:0] rc, input logic [7:0] rp);
    bus.coins = c;  bus.select_valid = sv; bus.select_id = sid; bus.cancel = cn;
    bus.restock_valid = rv; bus.restock_item = ri; bus.restock_count = rc; bus.restock_cost = rp;
    @(posedge clk);
    #1;
    bus.coins = 2'b00; bus.select_valid = 1'b0; bus.select_id = '0; bus.cancel = 1'b0;
    bus.restock_valid = 1'b0; bus.restock_item = '0; bus.restock_count = '0; bus.restock_cost = '0;
  endtask

  task automatic doIdle();                  applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0); endtask
  task automatic doCoin(input logic [1:0] c); applyStimulus(c, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0); endtask
  task automatic doSelect(input logic [2:0] id); applyStimulus(2'b00, 1'b1, id, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0); endtask
  task automatic doRestock(input logic [2:0] i, input logic [3:0] n, input logic [7:0] p);
    applyStimulus(2'b00, 1'b0, 3'd0, 1'b0, 1'b1, i, n, p);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hrst = 1'b1;
    bus.coins = 2'b00; bus.select_valid = 1'b0; bus.select_id = '0; bus.cancel = 1'b0;
    bus.restock_valid = 1'b0; bus.restock_item = '0; bus.restock_count = '0; bus.restock_cost = '0;
    #12;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_status", bus.status, 0);
    checkOutput("rst_balance", bus.balance, 0);
    checkOutput("rst_pvalid", bus.product_valid, 0);
    checkOutput("rst_cvalid", bus.change_valid, 0);
    checkOutput("rst_change", bus.change, 0);
    hrst = 1'b0;

    $display("[TB] restock slot 2 and buy with three quarters");
    doRestock(3'd2, 4'd5, 8'h4B);
    checkOutput("rs_busy", bus.busy, 1);
    doIdle();
    checkOutput("rs_status", bus.status, 0);
    checkOutput("rs_busy_low", bus.busy, 0);
    doSelect(3'd2);
    doIdle();
    checkOutput("sel_avail", bus.status, 1);
    checkOutput("sel_balance", bus.balance, 0);
    doCoin(2'b11);
    checkOutput("q1_balance", bus.balance, 25);
    doCoin(2'b11);
    doCoin(2'b11);
    checkOutput("q3_balance", bus.balance, 75);
    checkOutput("q3_no_pvalid", bus.product_valid, 0);
    doIdle();
    checkOutput("disp_pvalid", bus.product_valid, 1);
    checkOutput("disp_pid", bus.product_id, 2);
    checkOutput("disp_cvalid", bus.change_valid, 1);
    checkOutput("disp_change", bus.change, 0);
    doIdle();
    checkOutput("disp_strobe_end", bus.product_valid, 0);
    checkOutput("disp_bal0", bus.balance, 0);
    checkOutput("disp_stock", dut.stock_q[2], 4);

    $display("[TB] restock overflow on slot 3");
    doRestock(3'd3, 4'd10, 8'd20);
    doIdle();
    checkOutput("ov_first_ok", bus.status, 0);
    doRestock(3'd3, 4'd6, 8'd0);
    doIdle();
    checkOutput("ov_status_err", bus.status, 3);
    checkOutput("ov_stock_kept", dut.stock_q[3], 10);
    checkOutput("ov_price_kept", dut.price_q[3], 20);

    $display("[TB] empty slot select");
    doSelect(3'd5);
    checkOutput("oos_busy", bus.busy, 1);
    doIdle();
    checkOutput("oos_status", bus.status, 2);
    checkOutput("oos_busy_low", bus.busy, 0);
    checkOutput("oos_no_pvalid", bus.product_valid, 0);
    checkOutput("oos_no_cvalid", bus.change_valid, 0);

    $display("[TB] price 30 with change");
    doRestock(3'd1, 4'd3, 8'd30);
    doIdle();
    doSelect(3'd1);
    doIdle();
    checkOutput("p30_avail", bus.status, 1);
    doCoin(2'b11);
    doCoin(2'b10);
    checkOutput("p30_balance", bus.balance, 35);
    checkOutput("p30_no_pvalid", bus.product_valid, 0);
    doIdle();
    checkOutput("p30_cvalid", bus.change_valid, 1);
    checkOutput("p30_change", bus.change, 5);
    checkOutput("p30_pid", bus.product_id, 1);
    doCoin(2'b11);
    checkOutput("p30_coin_ignored", bus.balance, 0);
    checkOutput("p30_cvalid_end", bus.change_valid, 0);
    doCoin(2'b01);
    checkOutput("idle_coin_ignored", bus.balance, 0);

    $display("[TB] cancel with coin in the same cycle");
    doSelect(3'd1);
    doIdle();
    doCoin(2'b10);
    checkOutput("cn_balance", bus.balance, 10);
    applyStimulus(2'b10, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0);
    checkOutput("cn_cvalid", bus.change_valid, 1);
    checkOutput("cn_change", bus.change, 20);
    checkOutput("cn_no_pvalid", bus.product_valid, 0);
    doIdle();
    checkOutput("cn_bal0", bus.balance, 0);
    checkOutput("cn_busy_low", bus.busy, 0);

    $display("[TB] coin in the same cycle as the dispense decision");
    doSelect(3'd1);
    doIdle();
    doCoin(2'b11);
    doCoin(2'b10);
    doCoin(2'b01);
    checkOutput("ov_coin_pvalid", bus.product_valid, 1);
    checkOutput("ov_coin_change", bus.change, 10);
    doIdle();
    checkOutput("ov_coin_stock", dut.stock_q[1], 1);

    $display("[TB] watchdog refund");
    doSelect(3'd1);
    doIdle();
    doCoin(2'b01);
    for (int i = 1; i <= 15; i++) begin
      doIdle();
      checkOutput("to_wait_cvalid", bus.change_valid, 0);
    end
    doIdle();
    checkOutput("to_cvalid", bus.change_valid, 1);
    checkOutput("to_change", bus.change, 5);
    checkOutput("to_status", bus.status, 3);
    doIdle();
    checkOutput("to_busy_low", bus.busy, 0);

    $display("[TB] asynchronous reset mid-collect");
    doSelect(3'd1);
    doIdle();
    doCoin(2'b10);
    checkOutput("hr_pre_balance", bus.balance, 10);
    #2;
    hrst = 1'b1;
    #1;
    checkOutput("hr_busy", bus.busy, 0);
    checkOutput("hr_status", bus.status, 0);
    checkOutput("hr_balance", bus.balance, 0);
    checkOutput("hr_pid", bus.product_id, 0);
    checkOutput("hr_change", bus.change, 0);
    checkOutput("hr_stock", dut.stock_q[1], 0);
    hrst = 1'b0;
    doSelect(3'd1);
    doIdle();
    checkOutput("hr_after_oos", bus.status, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
